// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared constants for the register scoreboard: register count, register
// index width, default per-register outstanding-write counter width, and
// the hard-wired zero register index.
package reg_scoreboard_pkg;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 2;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
// Issue / writeback / flush bundle between the decode stage and the
// register scoreboard.
//   master : issue_* and rs* operand info, wb_valid/wb_rd, flush (driven);
//            stall, busy_mask, overflow_err (observed)
//   slave  : the scoreboard side, directions reversed
interface reg_scoreboard_if #(
  parameter int NREG = reg_scoreboard_pkg::NREG
);
  import reg_scoreboard_pkg::*;

  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_wen;
  logic             issue_long;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             rs1_used;
  logic             rs2_used;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             flush;
  logic             stall;
  logic [NREG-1:0]  busy_mask;
  logic             overflow_err;

  modport master (
    output issue_valid, issue_rd, issue_wen, issue_long,
    output rs1, rs2, rs1_used, rs2_used,
    output wb_valid, wb_rd, flush,
    input  stall, busy_mask, overflow_err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wen, issue_long,
    input  rs1, rs2, rs1_used, rs2_used,
    input  wb_valid, wb_rd, flush,
    output stall, busy_mask, overflow_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter
// Saturating up/down counter of outstanding long-latency writes for one
// architectural register.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (pipeline flush), wins over inc/dec
//   inc, dec : count up / down; both together leave the count unchanged
//   cnt      : current count
//   nz, full : count is non-zero / count is at its maximum
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             full
);
  assign nz   = (cnt != '0);
  assign full = (cnt == '1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && nz) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Tracks destination registers with long-latency writes in flight and
// raises a combinational decode stall on RAW (source pending) or WAW
// (destination counter saturated) hazards. Counts are released only by
// writeback, never by forwarding.
//   clk, rst : clock, synchronous active-high reset
//   sb       : reg_scoreboard_if.slave (issue, operands, writeback, flush,
//              stall, busy_mask, overflow_err)
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG  = reg_scoreboard_pkg::NREG,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  nz;
  logic [NREG-1:0]  full;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;

  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_wb;
  logic             raw;
  logic             waw;
  logic             stall_int;
  logic             accept;
  logic             inc;
  logic             dec;
  logic             wb_orphan;
  logic             suppress;
  logic [1:0]       supp_cnt;
  logic             ovf_q;

  // x0 is hard-wired: never tracked, never busy
  assign cnt[0]  = '0;
  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (sb.flush),
      .inc  (inc_vec[i]),
      .dec  (dec_vec[i]),
      .cnt  (cnt[i]),
      .nz   (nz[i]),
      .full (full[i])
    );
  end

  assign cnt_rs1 = cnt[sb.rs1];
  assign cnt_rs2 = cnt[sb.rs2];
  assign cnt_wb  = cnt[sb.wb_rd];

  always_comb begin
    raw       = (sb.rs1_used && (cnt_rs1 != '0)) ||
                (sb.rs2_used && (cnt_rs2 != '0));
    waw       = sb.issue_wen && sb.issue_long &&
                (sb.issue_rd != REG_ZERO) && full[sb.issue_rd];
    stall_int = sb.issue_valid && (raw || waw) && !sb.flush;
    accept    = sb.issue_valid && !stall_int && !sb.flush;
    inc       = accept && sb.issue_wen && sb.issue_long &&
                (sb.issue_rd != REG_ZERO);
    // Decrement uses the count before this edge, so a same-cycle
    // writeback never lowers stall; keeps wb -> stall off the timing path.
    dec       = sb.wb_valid && (sb.wb_rd != REG_ZERO) && (cnt_wb != '0) &&
                !sb.flush;
    wb_orphan = sb.wb_valid && (sb.wb_rd != REG_ZERO) && (cnt_wb == '0);
    // Writebacks for work discarded by a flush may still drain for two
    // cycles afterwards; those must not look like orphans.
    suppress  = sb.flush || (supp_cnt != 2'd0);

    inc_vec = '0;
    dec_vec = '0;
    if (inc) inc_vec[sb.issue_rd] = 1'b1;
    if (dec) dec_vec[sb.wb_rd]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      supp_cnt <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (sb.flush) begin
        supp_cnt <= 2'd2;
      end else if (supp_cnt != 2'd0) begin
        supp_cnt <= supp_cnt - 2'd1;
      end
      if (wb_orphan && !suppress) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign sb.stall        = stall_int;
  assign sb.busy_mask    = nz;
  assign sb.overflow_err = ovf_q;
endmodule
